ahb_reset_requester: RTL and testbench

//  AHB-Lite slave on the Cortex-M0 bus. Generates the cpu_request input of the system reset

---
 rtl/ahb_reset_requester_pkg.sv | 30 +++
 rtl/ahb_reset_requester_wdog_counter.sv | 58 +++++
 rtl/ahb_reset_requester.sv | 125 ++++++++++++
 tb/tb_ahb_reset_requester.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_reset_requester_pkg.sv
// Register map, CTRL bit positions, key defaults and bus pipeline types
// shared by the reset requester and its watchdog counter.
package ahb_reset_requester_pkg;

  typedef enum logic [2:0] {
    REG_LOAD   = 3'd0,
    REG_VALUE  = 3'd1,
    REG_CTRL   = 3'd2,
    REG_INTCLR = 3'd3,
    REG_RIS    = 3'd4,
    REG_SWRST  = 3'd5,
    REG_LOCK   = 3'd6,
    REG_RSVD   = 3'd7
  } regSel_e;

  localparam int CTRL_INTEN = 0;
  localparam int CTRL_RESEN = 1;

  localparam logic [31:0] SWRST_KEY_DEF  = 32'h05FA_0004;
  localparam logic [31:0] UNLOCK_KEY_DEF = 32'h1ACC_E551;
  localparam logic [31:0] LOAD_RST_DEF   = 32'h00FF_FFFF;

  // Address-phase capture carried into the data phase.
  typedef struct packed {
    logic    valid;
    logic    write;
    regSel_e sel;
  } busReq_t;

endpackage

// File: rtl/ahb_reset_requester_wdog_counter.sv
// Watchdog prescaler, down-counter and two-stage timeout: first timeout
// raises RIS, a timeout while RIS is still set requests reset if enabled.
module wdog_counter
  import ahb_reset_requester_pkg::*;
#(
  parameter int          PRESCALE = 16,
  parameter logic [31:0] LOAD_RST = LOAD_RST_DEF
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        enable,
  input  logic        reload,
  input  logic        clear,
  input  logic        resEn,
  input  logic [31:0] reloadVal,
  input  logic [31:0] loadVal,
  output logic [31:0] value,
  output logic        ris,
  output logic        timeoutReset
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          writeWins;

  assign tick      = enable && (presc == PRESC_MAX);
  assign writeWins = reload || clear;

  always_ff @(posedge clk) begin
    if (!rstN)                presc <= '0;
    else if (!enable || tick) presc <= '0;
    else                      presc <= presc + 1'b1;
  end

  // A bus reload/clear in the same cycle as a tick suppresses the tick.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      value <= LOAD_RST;
      ris   <= 1'b0;
    end else if (writeWins) begin
      value <= reloadVal;
      if (clear) ris <= 1'b0;
    end else if (tick) begin
      if (value != '0) begin
        value <= value - 1'b1;
      end else begin
        value <= loadVal;
        if (!ris) ris <= 1'b1;
      end
    end
  end

  assign timeoutReset = tick && (value == '0) && ris && resEn && !writeWins;

endmodule

// File: rtl/ahb_reset_requester.sv
// AHB-Lite slave producing the reset generator's cpu_request from a keyed
// software reset or the second watchdog timeout.
module ahb_reset_requester
  import ahb_reset_requester_pkg::*;
#(
  parameter int          PRESCALE   = 16,
  parameter logic [31:0] LOAD_RST   = LOAD_RST_DEF,
  parameter logic [31:0] SWRST_KEY  = SWRST_KEY_DEF,
  parameter logic [31:0] UNLOCK_KEY = UNLOCK_KEY_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        wdog_int,
  output logic        cpu_request,
  output logic [1:0]  req_src
);

  busReq_t     dph;
  logic [31:0] loadReg;
  logic [1:0]  ctrlReg;
  logic        locked;
  logic        wrEn, wrLoad, wrCtrl, wrIntclr, wrSwrst, wrLock;
  logic        cntEnable, cntReload;
  logic [31:0] cntReloadVal, cntValue;
  logic        risBit, timeoutReset;
  logic        unusedBits;

  assign unusedBits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0]};
  assign HREADYOUT  = 1'b1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dph <= '0;
    end else begin
      dph.valid <= HSEL & HTRANS[1] & HREADY;
      dph.write <= HWRITE;
      dph.sel   <= regSel_e'(HADDR[4:2]);
    end
  end

  assign wrEn     = dph.valid & dph.write;
  assign wrLoad   = wrEn & (dph.sel == REG_LOAD)   & !locked;
  assign wrCtrl   = wrEn & (dph.sel == REG_CTRL)   & !locked;
  assign wrIntclr = wrEn & (dph.sel == REG_INTCLR) & !locked;
  assign wrSwrst  = wrEn & (dph.sel == REG_SWRST);
  assign wrLock   = wrEn & (dph.sel == REG_LOCK);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      loadReg <= LOAD_RST;
      ctrlReg <= '0;
      locked  <= 1'b0;
    end else begin
      if (wrLoad) loadReg <= HWDATA;
      if (wrCtrl) ctrlReg <= HWDATA[1:0];
      if (wrLock) locked  <= (HWDATA != UNLOCK_KEY);
    end
  end

  // Clearing INTEN takes effect in the write cycle so a coincident timeout is dropped.
  assign cntEnable    = ctrlReg[CTRL_INTEN] & !(wrCtrl & !HWDATA[CTRL_INTEN]);
  assign cntReload    = wrLoad | wrIntclr |
                        (wrCtrl & HWDATA[CTRL_INTEN] & !ctrlReg[CTRL_INTEN]);
  assign cntReloadVal = wrLoad ? HWDATA : loadReg;

  wdog_counter #(
    .PRESCALE (PRESCALE),
    .LOAD_RST (LOAD_RST)
  ) uWdog (
    .clk          (HCLK),
    .rstN         (HRESETn),
    .enable       (cntEnable),
    .reload       (cntReload),
    .clear        (wrIntclr),
    .resEn        (ctrlReg[CTRL_RESEN]),
    .reloadVal    (cntReloadVal),
    .loadVal      (loadReg),
    .value        (cntValue),
    .ris          (risBit),
    .timeoutReset (timeoutReset)
  );

  // Sticky until bus reset; the reset this raises is what clears it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cpu_request <= 1'b0;
      req_src     <= '0;
    end else begin
      if (wrSwrst && (HWDATA == SWRST_KEY)) begin
        cpu_request <= 1'b1;
        req_src[0]  <= 1'b1;
      end
      if (timeoutReset) begin
        cpu_request <= 1'b1;
        req_src[1]  <= 1'b1;
      end
    end
  end

  assign wdog_int = risBit & ctrlReg[CTRL_INTEN];

  always_comb begin
    HRDATA = '0;
    if (dph.valid && !dph.write) begin
      case (dph.sel)
        REG_LOAD:  HRDATA = loadReg;
        REG_VALUE: HRDATA = cntValue;
        REG_CTRL:  HRDATA = {30'b0, ctrlReg};
        REG_RIS:   HRDATA = {31'b0, risBit};
        REG_LOCK:  HRDATA = {31'b0, locked};
        default:   HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_reset_requester.sv
// Bench for ahb_reset_requester with PRESCALE=1: register table, watchdog
// two-stage timeout, INTCLR servicing, software reset key and lock.
module tb_ahb_reset_requester;

  localparam logic [4:0] A_LOAD = 5'h00, A_VALUE = 5'h04, A_CTRL = 5'h08,
                         A_INTCLR = 5'h0C, A_RIS = 5'h10, A_SWRST = 5'h14,
                         A_LOCK = 5'h18, A_RSVD = 5'h1C;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT, wdog_int, cpu_request;
  logic [1:0]  req_src;

  ahb_reset_requester #(.PRESCALE(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .wdog_int(wdog_int),
    .cpu_request(cpu_request), .req_src(req_src)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected read data
    string       nm;
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [31:0] sbQ[$];
  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [4:0] a,
                              input logic [31:0] d, input string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.nm = n;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic busAddr(input logic w, input logic [4:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = {27'b0, a};
  endtask

  task automatic busIdle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge HCLK); busAddr(1'b1, a);
    @(negedge HCLK); busIdle(); HWDATA = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    @(negedge HCLK); busAddr(1'b0, a); sbQ.push_back(exp);
    @(negedge HCLK); busIdle();
    check(nm, HRDATA, sbQ.pop_front());
  endtask

  task automatic doReset();
    @(negedge HCLK); busIdle(); HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin : main
    logic [31:0] expVal[5];
    logic        expInt[5];
    logic        expReq[4];
    int          badCycles;

    vecs.push_back(mk(0, A_LOAD,   32'h00FF_FFFF, "rst LOAD"));
    vecs.push_back(mk(0, A_VALUE,  32'h00FF_FFFF, "rst VALUE"));
    vecs.push_back(mk(0, A_CTRL,   32'h0, "rst CTRL"));
    vecs.push_back(mk(0, A_INTCLR, 32'h0, "rst INTCLR"));
    vecs.push_back(mk(0, A_RIS,    32'h0, "rst RIS"));
    vecs.push_back(mk(0, A_SWRST,  32'h0, "rst SWRST"));
    vecs.push_back(mk(0, A_LOCK,   32'h0, "rst LOCK"));
    vecs.push_back(mk(0, A_RSVD,   32'h0, "rst RSVD"));
    vecs.push_back(mk(1, A_LOCK,   32'h0, ""));
    vecs.push_back(mk(1, A_LOAD,   32'h5, ""));
    vecs.push_back(mk(0, A_LOAD,   32'h00FF_FFFF, "locked LOAD"));
    vecs.push_back(mk(0, A_LOCK,   32'h1, "locked LOCK"));
    vecs.push_back(mk(1, A_CTRL,   32'h3, ""));
    vecs.push_back(mk(0, A_CTRL,   32'h0, "locked CTRL"));
    vecs.push_back(mk(1, A_LOCK,   32'h1ACC_E551, ""));
    vecs.push_back(mk(0, A_LOCK,   32'h0, "unlocked LOCK"));
    vecs.push_back(mk(1, A_LOAD,   32'h5, ""));
    vecs.push_back(mk(0, A_LOAD,   32'h5, "unlocked LOAD"));
    vecs.push_back(mk(0, A_VALUE,  32'h5, "LOAD reloads VALUE"));
    vecs.push_back(mk(1, A_RSVD,   32'hDEAD_BEEF, ""));
    vecs.push_back(mk(0, A_RSVD,   32'h0, "RSVD write ignored"));

    // Reset state and register table
    doReset();
    check("rst cpu_request", {31'b0, cpu_request}, 32'h0);
    check("rst req_src", {30'b0, req_src}, 32'h0);
    check("rst HREADYOUT", {31'b0, HREADYOUT}, 32'h1);
    check("rst HRDATA", HRDATA, 32'h0);
    check("rst wdog_int", {31'b0, wdog_int}, 32'h0);
    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].data, vecs[i].nm);
    end

    // Software reset key: wrong key ignored, right key requests on the data-phase edge
    wr(A_SWRST, 32'h1234_5678);
    @(negedge HCLK);
    check("swrst bad key", {31'b0, cpu_request}, 32'h0);
    wr(A_SWRST, 32'h05FA_0004);
    check("swrst before edge", {31'b0, cpu_request}, 32'h0);
    @(posedge HCLK); #1;
    check("swrst request", {31'b0, cpu_request}, 32'h1);
    check("swrst req_src", {30'b0, req_src}, 32'h1);

    // Watchdog two-stage timeout, VALUE sampled every cycle by pipelined reads
    doReset();
    wr(A_LOAD, 32'h3);
    wr(A_CTRL, 32'h3);
    expVal = '{32'h3, 32'h2, 32'h1, 32'h0, 32'h3};
    expInt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    busAddr(1'b0, A_VALUE); sbQ.push_back(expVal[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check($sformatf("wdog VALUE[%0d]", i), HRDATA, sbQ.pop_front());
      check($sformatf("wdog int[%0d]", i), {31'b0, wdog_int}, {31'b0, expInt[i]});
      if (i < 4) sbQ.push_back(expVal[i+1]);
      else       busIdle();
    end
    expReq = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check($sformatf("wdog req[%0d]", i), {31'b0, cpu_request}, {31'b0, expReq[i]});
    end
    check("wdog req_src", {30'b0, req_src}, 32'h2);
    @(negedge HCLK); HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    check("wdog req cleared", {31'b0, cpu_request}, 32'h0);
    check("wdog req_src cleared", {30'b0, req_src}, 32'h0);

    // Reset during a write data phase discards the write
    @(negedge HCLK); busAddr(1'b1, A_LOAD);
    @(negedge HCLK); busIdle(); HWDATA = 32'h7; HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    rd(A_LOAD, 32'h00FF_FFFF, "reset drops write");

    // Periodic INTCLR keeps the watchdog from ever timing out
    wr(A_LOAD, 32'h3);
    wr(A_CTRL, 32'h3);
    badCycles = 0;
    for (int i = 0; i < 34; i++) begin
      wr(A_INTCLR, 32'h0);
      if (cpu_request || wdog_int) badCycles++;
      @(negedge HCLK);
      if (cpu_request || wdog_int) badCycles++;
    end
    check("intclr no event cycles", badCycles, 32'h0);
    rd(A_RIS, 32'h0, "intclr RIS");
    check("intclr cpu_request", {31'b0, cpu_request}, 32'h0);

    // INTCLR data phase on the same edge as a second timeout: clear wins
    doReset();
    wr(A_LOAD, 32'h0);
    wr(A_CTRL, 32'h3);
    @(negedge HCLK); busAddr(1'b1, A_INTCLR);
    @(negedge HCLK); busIdle(); HWDATA = 32'h0;
    check("coinc RIS set", {31'b0, wdog_int}, 32'h1);
    @(posedge HCLK); #1;
    check("coinc RIS cleared", {31'b0, wdog_int}, 32'h0);
    check("coinc no request", {31'b0, cpu_request}, 32'h0);
    wr(A_CTRL, 32'h0);
    rd(A_VALUE, 32'h0, "coinc VALUE=LOAD");
    check("coinc still no request", {31'b0, cpu_request}, 32'h0);

    check("scoreboard drained", sbQ.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
